param_accum_alu: RTL and testbench
==================================

PARAM_ACCUM_ALU -- requirements
Module: param_accum_alu

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/accumulator/result width in bits (WIDTH >= 2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 on  in  1  enable; 0 forces S_OFF.
REQ-005 op_valid  in  1  operation request.
REQ-006 op_ready  out  1  block can accept; high only in S_READY.
REQ-007 op_code  in  3  000 AND, 001 OR, 010 XOR, 011 NOT, 100 ADD, 101 SUB, 110 MUL, 111 reserved.
REQ-008 src_sel  in  2  A-operand source: 00 persist (accumulator), 01 load operand_a, 10 clear (zero), 11 treated as 00.
REQ-009 operand_a  in  WIDTH  external A operand.
REQ-010 operand_b  in  WIDTH  B operand.
REQ-011 err_clr  in  1  leaves S_ERROR and clears error flags.
REQ-012 result  out  WIDTH  registered result of last completed operation.
REQ-013 result_valid  out  1  one-cycle completion pulse.
REQ-014 ovf  out  1  sticky overflow flag.
REQ-015 err_code  out  2  00 none, 01 overflow, 10 illegal opcode.
REQ-016 state  out  2  current FSM state.

Function
REQ-017 FSM states SHALL be S_OFF=00, S_READY=01, S_RUN=10, S_ERROR=11.
REQ-018 Transitions: S_OFF->S_READY when on=1; S_READY->S_RUN on op_valid&op_ready; S_RUN->S_READY on completion without error; S_RUN->S_ERROR on overflow; S_READY->S_ERROR on accepted reserved opcode; S_ERROR->S_READY on err_clr.
REQ-019 on=0 in any state SHALL force S_OFF at next edge, overriding all other transitions, including err_clr.
REQ-020 On accept, A operand (per src_sel) and operand_b SHALL be captured; later input changes have no effect.
REQ-021 NOT SHALL compute ~A; operand_b ignored.
REQ-022 AND/OR/XOR/NOT/ADD/SUB latency: S_RUN lasts 1 cycle; result and result_valid update at the edge leaving S_RUN.
REQ-023 MUL SHALL be iterative shift-add: S_RUN lasts WIDTH cycles; result = low WIDTH bits of A*B.
REQ-024 Overflow: ADD carry-out=1; SUB unsigned A<B (borrow); MUL upper WIDTH bits nonzero.
REQ-025 On completion, result and accumulator SHALL take the truncated result and result_valid SHALL pulse, with or without overflow.
REQ-026 On overflow, ovf SHALL set, err_code SHALL become 01, FSM SHALL enter S_ERROR.
REQ-027 Reserved opcode SHALL set err_code=10, leave accumulator/result unchanged, give no result_valid, leave ovf unchanged.
REQ-028 In S_ERROR and S_OFF, op_valid SHALL be ignored; err_clr SHALL clear ovf and err_code.
REQ-029 on=0 mid-MUL SHALL abort: no result_valid, accumulator and result unchanged.
REQ-030 Accumulator, result and flags SHALL be retained through S_OFF.

Reset
REQ-031 rst_n=0 SHALL immediately set state=S_OFF, accumulator=0, result=0, result_valid=0, ovf=0, err_code=00, multiplier counter/registers=0.
REQ-032 Reset mid-operation SHALL discard it with no result_valid.

Configuration
REQ-033 With ALU_MULT_EN defined, MUL SHALL be implemented per REQ-023.
REQ-034 Without ALU_MULT_EN, no multiplier logic SHALL exist and op_code 110 SHALL behave as reserved (REQ-027).

Structure
REQ-035 Package alu_pkg SHALL hold state encodings, op_code and src_sel constants, err_code constants.
REQ-036 Sub-module alu_seq_mult (parameter WIDTH; start, A, B in; done, product low/high out) SHALL implement the iterative multiplier.

Verification (WIDTH=8)
REQ-037 Reset, on=1 -> state 00 during reset, 01 one edge after release, op_ready=1.
REQ-038 ADD src_sel=01 a=0x05 b=0x03 -> result 0x08, one result_valid pulse, back to S_READY; then SUB src_sel=00 b=0x08 -> 0x00, ovf=0.
REQ-039 ADD a=0xF0 b=0x20 -> result 0x10, ovf=1, err_code=01, S_ERROR, op_ready=0; err_clr -> S_READY, ovf=0, err_code=00.
REQ-040 MUL a=0x0C b=0x0B -> result 0x84 after 8 S_RUN cycles; MUL a=0x20 b=0x10 -> 0x00, ovf=1, S_ERROR.
REQ-041 on=0 on 3rd MUL cycle -> S_OFF next edge, no result_valid, accumulator unchanged.
REQ-042 op_code 111 (and 110 without ALU_MULT_EN) -> S_ERROR, err_code=10, no result_valid, accumulator unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for param_accum_alu: FSM states, op codes, A-source selects,
// error codes. Optional feature macro: ALU_MULT_EN (enables the MUL op code).
package alu_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_e;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [1:0] SRC_ACC   = 2'b00;
  localparam logic [1:0] SRC_LOAD  = 2'b01;
  localparam logic [1:0] SRC_CLEAR = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  // Op codes rejected at accept time; MUL is illegal when no multiplier is built.
  function automatic logic op_is_reserved(input logic [2:0] op);
`ifdef ALU_MULT_EN
    return (op == OP_RSVD);
`else
    return (op == OP_RSVD) || (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier. The first partial product is folded into the
// start edge so that done rises in the WIDTH-th cycle after start, one cycle wide.
module alu_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  logic [PROD_W-1:0] mcand_q;
  logic [PROD_W-1:0] acc_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]  cnt_q;

  assign product_lo = acc_q[WIDTH-1:0];
  assign product_hi = acc_q[PROD_W-1:WIDTH];

  // One shift-add step per cycle; a new start always restarts from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_q <= b >> 1;
      cnt_q    <= CNT_W'(WIDTH - 1);
      done     <= 1'b0;
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= {mcand_q[PROD_W-2:0], 1'b0};
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      done     <= (cnt_q == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/param_accum_alu.sv
// Accumulator ALU with a 4-state control FSM, sticky overflow and error codes.
// Optional feature macro: ALU_MULT_EN builds the iterative multiplier for op 110.
module param_accum_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [1:0]       src_sel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf,
  output logic [1:0]       err_code,
  output logic [1:0]       state
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] a_sel_c;
  logic             accept_c;
  logic [WIDTH:0]   wide_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_done_c;

  assign state    = state_q;
  assign accept_c = on && op_valid && op_ready && (state_q == S_READY);

  // A-operand source selection; code 11 falls back to the accumulator.
  always_comb begin
    a_sel_c = acc_q;
    case (src_sel)
      SRC_LOAD:  a_sel_c = operand_a;
      SRC_CLEAR: a_sel_c = '0;
      default:   a_sel_c = acc_q;
    endcase
  end

`ifdef ALU_MULT_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;

  alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept_c && (op_code == OP_MUL)),
    .a          (a_sel_c),
    .b          (operand_b),
    .done       (mul_done),
    .product_lo (mul_lo),
    .product_hi (mul_hi)
  );
`endif

  // Result, overflow and completion for the captured operation.
  always_comb begin
    wide_c     = '0;
    alu_res_c  = '0;
    alu_ovf_c  = 1'b0;
    alu_done_c = 1'b1;
    case (op_q)
      OP_AND: alu_res_c = a_q & b_q;
      OP_OR:  alu_res_c = a_q | b_q;
      OP_XOR: alu_res_c = a_q ^ b_q;
      OP_NOT: alu_res_c = ~a_q;
      OP_ADD: begin
        wide_c    = {1'b0, a_q} + {1'b0, b_q};
        alu_res_c = wide_c[WIDTH-1:0];
        alu_ovf_c = wide_c[WIDTH];
      end
      OP_SUB: begin
        wide_c    = {1'b0, a_q} - {1'b0, b_q};
        alu_res_c = wide_c[WIDTH-1:0];
        alu_ovf_c = wide_c[WIDTH];
      end
`ifdef ALU_MULT_EN
      OP_MUL: begin
        alu_res_c  = mul_lo;
        alu_ovf_c  = |mul_hi;
        alu_done_c = mul_done;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM with registered datapath and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      op_ready     <= 1'b0;
      acc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_AND;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      result_valid <= 1'b0;
      if (err_clr && ((state_q == S_ERROR) || (state_q == S_OFF))) begin
        ovf      <= 1'b0;
        err_code <= ERR_NONE;
      end
      if (!on) begin
        state_q  <= S_OFF;
        op_ready <= 1'b0;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q  <= S_READY;
            op_ready <= 1'b1;
          end
          S_READY: begin
            if (accept_c) begin
              a_q      <= a_sel_c;
              b_q      <= operand_b;
              op_q     <= op_code;
              op_ready <= 1'b0;
              if (op_is_reserved(op_code)) begin
                err_code <= ERR_ILLEGAL;
                state_q  <= S_ERROR;
              end else begin
                state_q <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (alu_done_c) begin
              result       <= alu_res_c;
              acc_q        <= alu_res_c;
              result_valid <= 1'b1;
              if (alu_ovf_c) begin
                ovf      <= 1'b1;
                err_code <= ERR_OVF;
                state_q  <= S_ERROR;
              end else begin
                state_q  <= S_READY;
                op_ready <= 1'b1;
              end
            end
          end
          S_ERROR: begin
            if (err_clr) begin
              state_q  <= S_READY;
              op_ready <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_OFF;
            op_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_accum_alu.sv
// Directed scoreboard bench for param_accum_alu (WIDTH=8). MUL expectations follow ALU_MULT_EN.
module tb_param_accum_alu;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             on;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [1:0]       src_sel;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             err_clr;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             ovf;
  logic [1:0]       err_code;
  logic [1:0]       state;

  int checks   = 0;
  int passed   = 0;
  int fails    = 0;
  int rv_count = 0;
  int n_pushed = 0;
  logic [WIDTH-1:0] exp_q[$];

  param_accum_alu #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .on           (on),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .src_sel      (src_sel),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .err_clr      (err_clr),
    .result       (result),
    .result_valid (result_valid),
    .ovf          (ovf),
    .err_code     (err_code),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; checks the RUN length and the state/pulse on leaving RUN.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] src,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int run_cycles, input logic [1:0] exp_state,
                        input logic [WIDTH-1:0] exp_res, input logic exp_rv);
    if (exp_rv) begin
      exp_q.push_back(exp_res);
      n_pushed++;
    end
    op_code   = op;
    src_sel   = src;
    operand_a = a;
    operand_b = b;
    op_valid  = 1'b1;
    step();
    op_valid  = 1'b0;
    operand_a = WIDTH'($urandom);
    operand_b = WIDTH'($urandom);
    src_sel   = 2'($urandom);
    op_code   = 3'($urandom);
    if (run_cycles > 0) begin
      repeat (run_cycles - 1) step();
      check({tag, "_run"}, 32'(state), 32'(S_RUN));
      step();
    end
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_rv"}, 32'(result_valid), 32'(exp_rv));
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check({tag, "_state"}, 32'(state), 32'(S_READY));
    check({tag, "_ovf"}, 32'(ovf), 32'(0));
    check({tag, "_err"}, 32'(err_code), 32'(ERR_NONE));
  endtask

  // Scoreboard: every result_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) check("unexpected_rv", 32'(result_valid), 32'(0));
      else check("result", 32'(result), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst_n     = 1'b0;
    on        = 1'b1;
    op_valid  = 1'b0;
    op_code   = OP_AND;
    src_sel   = SRC_ACC;
    operand_a = '0;
    operand_b = '0;
    err_clr   = 1'b0;

    repeat (2) step();
    check("rst_state", 32'(state), 32'(S_OFF));
    check("rst_ready", 32'(op_ready), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_rv", 32'(result_valid), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_err", 32'(err_code), 32'(ERR_NONE));
    rst_n = 1'b1;
    step();
    check("rel_state", 32'(state), 32'(S_READY));
    check("rel_ready", 32'(op_ready), 32'(1));

    run_op("add1", OP_ADD, SRC_LOAD, 8'h05, 8'h03, 1, S_READY, 8'h08, 1'b1);
    check("add1_ovf", 32'(ovf), 32'(0));
    step();
    check("rv_one_cycle", 32'(result_valid), 32'(0));
    run_op("sub1", OP_SUB, SRC_ACC, 8'hAA, 8'h08, 1, S_READY, 8'h00, 1'b1);
    check("sub1_ovf", 32'(ovf), 32'(0));
    check("sub1_err", 32'(err_code), 32'(ERR_NONE));

    run_op("add_ovf", OP_ADD, SRC_LOAD, 8'hF0, 8'h20, 1, S_ERROR, 8'h10, 1'b1);
    check("add_ovf_flag", 32'(ovf), 32'(1));
    check("add_ovf_err", 32'(err_code), 32'(ERR_OVF));
    check("add_ovf_ready", 32'(op_ready), 32'(0));
    op_valid = 1'b1;
    op_code  = OP_ADD;
    src_sel  = SRC_LOAD;
    repeat (2) step();
    op_valid = 1'b0;
    check("err_ignores_req", 32'(state), 32'(S_ERROR));
    clear_err("clr1");

    run_op("and", OP_AND, SRC_LOAD, 8'hCC, 8'hAA, 1, S_READY, 8'h88, 1'b1);
    run_op("or", OP_OR, SRC_ACC, 8'h00, 8'h01, 1, S_READY, 8'h89, 1'b1);
    run_op("xor", OP_XOR, SRC_ACC, 8'h00, 8'hFF, 1, S_READY, 8'h76, 1'b1);
    run_op("not_acc", OP_NOT, SRC_ACC, 8'h12, 8'h34, 1, S_READY, 8'h89, 1'b1);
    run_op("not_clr", OP_NOT, SRC_CLEAR, 8'h12, 8'h34, 1, S_READY, 8'hFF, 1'b1);
    run_op("or_src11", OP_OR, 2'b11, 8'h00, 8'h00, 1, S_READY, 8'hFF, 1'b1);
    run_op("sub_borrow", OP_SUB, SRC_CLEAR, 8'h55, 8'h01, 1, S_ERROR, 8'hFF, 1'b1);
    check("borrow_ovf", 32'(ovf), 32'(1));
    check("borrow_err", 32'(err_code), 32'(ERR_OVF));

    on      = 1'b0;
    err_clr = 1'b1;
    step();
    check("off_beats_clr", 32'(state), 32'(S_OFF));
    step();
    err_clr = 1'b0;
    check("off_clr_ovf", 32'(ovf), 32'(0));
    check("off_clr_err", 32'(err_code), 32'(ERR_NONE));
    on = 1'b1;
    step();
    check("off_to_ready", 32'(state), 32'(S_READY));

`ifdef ALU_MULT_EN
    run_op("mul1", OP_MUL, SRC_LOAD, 8'h0C, 8'h0B, 8, S_READY, 8'h84, 1'b1);
    check("mul1_ovf", 32'(ovf), 32'(0));
    run_op("mul_ovf", OP_MUL, SRC_LOAD, 8'h20, 8'h10, 8, S_ERROR, 8'h00, 1'b1);
    check("mul_ovf_flag", 32'(ovf), 32'(1));
    check("mul_ovf_err", 32'(err_code), 32'(ERR_OVF));
    clear_err("clr_mul");
`endif

    run_op("add33", OP_ADD, SRC_LOAD, 8'h33, 8'h00, 1, S_READY, 8'h33, 1'b1);

`ifdef ALU_MULT_EN
    op_code   = OP_MUL;
    src_sel   = SRC_LOAD;
    operand_a = 8'h03;
    operand_b = 8'h05;
    op_valid  = 1'b1;
    step();
    op_valid = 1'b0;
    repeat (2) step();
    check("abort_in_run", 32'(state), 32'(S_RUN));
    on = 1'b0;
    step();
    check("abort_state", 32'(state), 32'(S_OFF));
    check("abort_rv", 32'(result_valid), 32'(0));
    check("abort_result", 32'(result), 32'(8'h33));
    on = 1'b1;
    step();
    check("abort_ready", 32'(state), 32'(S_READY));
    repeat (8) step();
`else
    run_op("mul_rsvd", OP_MUL, SRC_LOAD, 8'h07, 8'h07, 0, S_ERROR, 8'h00, 1'b0);
    check("mul_rsvd_err", 32'(err_code), 32'(ERR_ILLEGAL));
    check("mul_rsvd_ovf", 32'(ovf), 32'(0));
    check("mul_rsvd_result", 32'(result), 32'(8'h33));
    clear_err("clr_mulrsvd");
`endif

    run_op("rsvd", OP_RSVD, SRC_LOAD, 8'h77, 8'h11, 0, S_ERROR, 8'h00, 1'b0);
    check("rsvd_err", 32'(err_code), 32'(ERR_ILLEGAL));
    check("rsvd_ovf", 32'(ovf), 32'(0));
    check("rsvd_result", 32'(result), 32'(8'h33));
    check("rsvd_ready", 32'(op_ready), 32'(0));
    on = 1'b0;
    step();
    check("rsvd_off", 32'(state), 32'(S_OFF));
    check("off_keeps_err", 32'(err_code), 32'(ERR_ILLEGAL));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("off_err_cleared", 32'(err_code), 32'(ERR_NONE));
    on = 1'b1;
    step();
    check("rsvd_ready_again", 32'(state), 32'(S_READY));
    run_op("readback", OP_OR, SRC_ACC, 8'hEE, 8'h00, 1, S_READY, 8'h33, 1'b1);

    op_code   = OP_ADD;
    src_sel   = SRC_LOAD;
    operand_a = 8'h01;
    operand_b = 8'h01;
    op_valid  = 1'b1;
    step();
    op_valid = 1'b0;
    check("rstmid_run", 32'(state), 32'(S_RUN));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_state", 32'(state), 32'(S_OFF));
    check("rstmid_result", 32'(result), 32'(0));
    check("rstmid_rv", 32'(result_valid), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    check("rstmid_ready", 32'(state), 32'(S_READY));

    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("rv_count", 32'(rv_count), 32'(n_pushed));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
